// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - display-update handshake bundle for seg7_scan_ctrl
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits_in;
    logic [DIGITS-1:0]   dp_in;
    logic                blank_lz;
    logic                upd_req;
    logic                upd_ack;

    // Application side: presents new display data and holds req until ack.
    modport master (
        output digits_in,
        output dp_in,
        output blank_lz,
        output upd_req,
        input  upd_ack
    );

    // Display controller side: captures data only at frame boundaries.
    modport slave (
        input  digits_in,
        input  dp_in,
        input  blank_lz,
        input  upd_req,
        output upd_ack
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scanner with blanking gap, hex decode and LZ blanking
module seg7_scan_ctrl #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 500,
    parameter int COMMON_ANODE = 0
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       en,
    seg7_scan_ctrl_if.slave            upd,
    output logic [6:0]                 seg_out,
    output logic                       dp_out,
    output logic [DIGITS-1:0]          an_out,
    output logic [$clog2(DIGITS)-1:0]  digit_idx,
    output logic                       frame_tick
);
    localparam int   SLOT = CLK_HZ / SCAN_HZ;
    localparam int   CW   = $clog2(SLOT);
    localparam int   IW   = $clog2(DIGITS);
    localparam logic INV  = (COMMON_ANODE != 0);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [IW-1:0]       idx, idx_d;
    logic                frame_start;

    logic [4*DIGITS-1:0] sh_dig, sh_dig_d;
    logic [DIGITS-1:0]   sh_dp, sh_dp_d;
    logic                sh_lz, sh_lz_d;
    logic                ack_d;

    logic [DIGITS-1:0]   blank_vec;
    logic                zero_run;
    logic                lit_d;
    logic [3:0]          nib_d;
    logic [6:0]          seg_d;
    logic                dp_d;
    logic [DIGITS-1:0]   an_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Scan sequencing: slot counter, digit index, frame-start detection.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        idx_d       = idx;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (en) begin
                    state_d     = SCAN;
                    frame_start = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt == CW'(SLOT - 1)) begin
                    cnt_d = '0;
                    if (idx == IW'(DIGITS - 1)) begin
                        idx_d       = '0;
                        frame_start = 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
        endcase
    end

    // Shadow capture happens only on a frame-start edge so a frame never mixes old and new data.
    always_comb begin
        sh_dig_d = sh_dig;
        sh_dp_d  = sh_dp;
        sh_lz_d  = sh_lz;
        ack_d    = 1'b0;
        if (frame_start && upd.upd_req) begin
            sh_dig_d = upd.digits_in;
            sh_dp_d  = upd.dp_in;
            sh_lz_d  = upd.blank_lz;
            ack_d    = 1'b1;
        end
    end

    // Leading-zero mask: walk from the top digit down while every nibble seen so far is zero.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (sh_dig_d[4*i +: 4] == 4'h0);
            blank_vec[i] = sh_lz_d & zero_run & ~sh_dp_d[i] & (i != 0);
        end
    end

    // Segment/enable pattern for the upcoming cycle, before polarity inversion.
    always_comb begin
        nib_d = sh_dig_d[idx_d*4 +: 4];
        lit_d = (state_d == SCAN) && (cnt_d >= CW'(BLANK_CYCLES)) && !blank_vec[idx_d];
        seg_d = lit_d ? hex7(nib_d) : 7'h00;
        dp_d  = lit_d & sh_dp_d[idx_d];
        an_d  = '0;
        if (lit_d) begin
            an_d[idx_d] = 1'b1;
        end
    end

    // State, shadow and output registers; outputs are registered from next-state values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            sh_dig      <= '0;
            sh_dp       <= '0;
            sh_lz       <= 1'b0;
            seg_out     <= {7{INV}};
            dp_out      <= INV;
            an_out      <= {DIGITS{INV}};
            frame_tick  <= 1'b0;
            upd.upd_ack <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            sh_dig      <= sh_dig_d;
            sh_dp       <= sh_dp_d;
            sh_lz       <= sh_lz_d;
            seg_out     <= seg_d ^ {7{INV}};
            dp_out      <= dp_d ^ INV;
            an_out      <= an_d ^ {DIGITS{INV}};
            frame_tick  <= frame_start;
            upd.upd_ack <= ack_d;
        end
    end

    assign digit_idx = idx;
endmodule
